// File: rtl/fe_de_queue.sv
// fe_de_queue: receiving end of the fetch-to-decode interface.
// Captures {pc, isn} pairs from fetch into a small in-order queue and presents
// the oldest entry to decode through a valid/ready handshake.
// Ports:
//   clk        pipeline clock, rising edge
//   rst        asynchronous reset, active-low; queue cleared while low
//   fe_valid   fetch presents {fe_pc, fe_isn} this cycle
//   fe_pc      pc of presented instruction
//   fe_isn     presented instruction word
//   stall      to fetch; 1 = queue full, nothing accepted
//   flush      discard all queued entries (branch redirect / exception)
//   de_valid   head entry valid for decode
//   de_pc      pc of head entry (0 when empty)
//   de_isn     instruction word of head entry (0 when empty)
//   de_ready   decode consumes the head entry this cycle
//   occupancy  number of valid entries
module fe_de_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fe_valid,
   input  logic [AW-1:0]                fe_pc,
   input  logic [AW-1:0]                fe_isn,
   output logic                         stall,
   input  logic                         flush,
   output logic                         de_valid,
   output logic [AW-1:0]                de_pc,
   output logic [AW-1:0]                de_isn,
   input  logic                         de_ready,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [AW-1:0] isn;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   entry_t        head_q, head_d;
   logic          stall_q, stall_d;
   logic          valid_q, valid_d;
   logic          enq, deq;

   // Next-state: pointers, count, and the registered view of the next head.
   always_comb begin
      enq      = fe_valid & ~stall_q & ~flush;
      deq      = valid_q & de_ready & ~flush;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      head_d   = '0;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
         if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      // The new head is the word being written when it lands in the slot
      // rd_ptr will point at (empty queue, or single entry being replaced).
      if (count_d != '0) begin
         if (enq && (rd_ptr_d == wr_ptr_q)) head_d = {fe_pc, fe_isn};
         else                               head_d = mem_q[rd_ptr_d];
      end

      stall_d = (count_d == CW'(DEPTH));
      valid_d = (count_d != '0);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         stall_q  <= 1'b0;
         valid_q  <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         stall_q  <= stall_d;
         valid_q  <= valid_d;
         if (enq) mem_q[wr_ptr_q] <= {fe_pc, fe_isn};
      end
   end

   assign stall     = stall_q;
   assign de_valid  = valid_q;
   assign de_pc     = head_q.pc;
   assign de_isn    = head_q.isn;
   assign occupancy = count_q;

   // Occupancy bounds: never above DEPTH, never consume from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         assert (count_q <= CW'(DEPTH));
         assert (!(deq && (count_q == '0)));
      end
   end

endmodule

// File: tb/tb_fe_de_queue.sv
// tb_fe_de_queue: directed bench for fe_de_queue (fill, drain, streaming,
// flush, full-with-drain, asynchronous reset).
module tb_fe_de_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 32;
   localparam int unsigned CW    = $clog2(DEPTH+1);

   logic          clk;
   logic          rst;
   logic          fe_valid;
   logic [AW-1:0] fe_pc;
   logic [AW-1:0] fe_isn;
   logic          stall;
   logic          flush;
   logic          de_valid;
   logic [AW-1:0] de_pc;
   logic [AW-1:0] de_isn;
   logic          de_ready;
   logic [CW-1:0] occupancy;

   int vectors;
   int miscompares;

   fe_de_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .fe_valid  (fe_valid),
      .fe_pc     (fe_pc),
      .fe_isn    (fe_isn),
      .stall     (stall),
      .flush     (flush),
      .de_valid  (de_valid),
      .de_pc     (de_pc),
      .de_isn    (de_isn),
      .de_ready  (de_ready),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      vectors++; if (de_valid !== 1'b0) begin miscompares++; $display("FAIL reset_de_valid got %b exp 0", de_valid); end
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", stall); end
      vectors++; if (occupancy !== CW'(0)) begin miscompares++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
      vectors++; if (de_pc !== 32'h0 || de_isn !== 32'h0) begin miscompares++; $display("FAIL reset_de_data got %h/%h exp 0/0", de_pc, de_isn); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_fill();
      de_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         fe_valid = 1'b1; fe_pc = 32'(4*i); fe_isn = 32'(8'hA0 + i);
         tick();
         vectors++; if (occupancy !== CW'(i+1)) begin miscompares++; $display("FAIL fill_occ[%0d] got %0d exp %0d", i, occupancy, i+1); end
         vectors++; if (stall !== (i == 3)) begin miscompares++; $display("FAIL fill_stall[%0d] got %b exp %b", i, stall, (i == 3)); end
         vectors++; if (de_pc !== 32'h0 || de_isn !== 32'hA0) begin miscompares++; $display("FAIL fill_head[%0d] got %h/%h exp 0/a0", i, de_pc, de_isn); end
      end
      fe_pc = 32'h10; fe_isn = 32'hA4;
      tick();
      fe_valid = 1'b0;
      vectors++; if (occupancy !== CW'(4) || stall !== 1'b1) begin miscompares++; $display("FAIL fill_fifth got occ %0d stall %b exp 4 1", occupancy, stall); end
      vectors++; if (de_pc !== 32'h0) begin miscompares++; $display("FAIL fill_fifth_head got %h exp 0", de_pc); end
   endtask

   task automatic test_drain();
      fe_valid = 1'b0; de_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (de_valid !== 1'b1 || de_pc !== 32'(4*i) || de_isn !== 32'(8'hA0 + i)) begin
            miscompares++; $display("FAIL drain_head[%0d] got v%b %h/%h exp v1 %h/%h", i, de_valid, de_pc, de_isn, 32'(4*i), 32'(8'hA0 + i)); end
         tick();
         if (i == 0) begin
            vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL drain_stall got %b exp 0", stall); end
         end
      end
      de_ready = 1'b0;
      vectors++; if (de_valid !== 1'b0 || de_pc !== 32'h0 || occupancy !== CW'(0)) begin
         miscompares++; $display("FAIL drain_empty got v%b pc %h occ %0d exp v0 0 0", de_valid, de_pc, occupancy); end
      // de_ready on an empty queue must be ignored
      de_ready = 1'b1;
      tick();
      de_ready = 1'b0;
      vectors++; if (occupancy !== CW'(0) || de_valid !== 1'b0) begin miscompares++; $display("FAIL empty_ready got occ %0d v%b exp 0 v0", occupancy, de_valid); end
   endtask

   task automatic test_stream();
      fe_valid = 1'b1; de_ready = 1'b1;
      for (int i = 0; i < 2*DEPTH + 2; i++) begin
         fe_pc = 32'h100 + 32'(4*i); fe_isn = 32'hB00 + 32'(i);
         tick();
         vectors++; if (occupancy !== CW'(1) || stall !== 1'b0) begin miscompares++; $display("FAIL stream_occ[%0d] got occ %0d stall %b exp 1 0", i, occupancy, stall); end
         vectors++; if (de_pc !== 32'h100 + 32'(4*i) || de_isn !== 32'hB00 + 32'(i)) begin
            miscompares++; $display("FAIL stream_head[%0d] got %h/%h exp %h/%h", i, de_pc, de_isn, 32'h100 + 32'(4*i), 32'hB00 + 32'(i)); end
      end
      fe_valid = 1'b0;
      tick();
      de_ready = 1'b0;
      vectors++; if (occupancy !== CW'(0)) begin miscompares++; $display("FAIL stream_drain got occ %0d exp 0", occupancy); end
   endtask

   task automatic test_flush();
      de_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fe_valid = 1'b1; fe_pc = 32'h50 + 32'(4*i); fe_isn = 32'hD0 + 32'(i);
         tick();
      end
      vectors++; if (occupancy !== CW'(3)) begin miscompares++; $display("FAIL flush_pre_occ got %0d exp 3", occupancy); end
      flush = 1'b1; fe_valid = 1'b1; fe_pc = 32'h200; fe_isn = 32'hEE; de_ready = 1'b1;
      tick();
      flush = 1'b0; fe_valid = 1'b0; de_ready = 1'b0;
      vectors++; if (occupancy !== CW'(0) || de_valid !== 1'b0 || stall !== 1'b0) begin
         miscompares++; $display("FAIL flush_post got occ %0d v%b stall %b exp 0 v0 0", occupancy, de_valid, stall); end
      vectors++; if (de_pc !== 32'h0 || de_isn !== 32'h0) begin miscompares++; $display("FAIL flush_data got %h/%h exp 0/0", de_pc, de_isn); end
      tick();
      vectors++; if (occupancy !== CW'(0) || de_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped got occ %0d v%b exp 0 v0", occupancy, de_valid); end
      fe_valid = 1'b1; fe_pc = 32'h300; fe_isn = 32'h33;
      tick();
      fe_valid = 1'b0;
      vectors++; if (de_valid !== 1'b1 || de_pc !== 32'h300 || de_isn !== 32'h33 || occupancy !== CW'(1)) begin
         miscompares++; $display("FAIL flush_refill got v%b %h/%h occ %0d exp v1 300/33 1", de_valid, de_pc, de_isn, occupancy); end
      // flush from a full queue releases stall on the next cycle
      for (int i = 0; i < 3; i++) begin
         fe_valid = 1'b1; fe_pc = 32'h310 + 32'(4*i); fe_isn = 32'h0;
         tick();
      end
      fe_valid = 1'b0;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL flush_full_pre got stall %b exp 1", stall); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vectors++; if (stall !== 1'b0 || occupancy !== CW'(0)) begin miscompares++; $display("FAIL flush_full_post got stall %b occ %0d exp 0 0", stall, occupancy); end
   endtask

   task automatic test_full_drain();
      de_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         fe_valid = 1'b1; fe_pc = 32'h40 + 32'(4*i); fe_isn = 32'hC0 + 32'(i);
         tick();
      end
      vectors++; if (stall !== 1'b1 || occupancy !== CW'(4)) begin miscompares++; $display("FAIL full_pre got stall %b occ %0d exp 1 4", stall, occupancy); end
      fe_valid = 1'b1; fe_pc = 32'h20; fe_isn = 32'hF0; de_ready = 1'b1;
      tick();
      vectors++; if (occupancy !== CW'(3) || stall !== 1'b0 || de_pc !== 32'h44) begin
         miscompares++; $display("FAIL full_same_cycle got occ %0d stall %b pc %h exp 3 0 44", occupancy, stall, de_pc); end
      de_ready = 1'b0;
      tick();
      fe_valid = 1'b0;
      vectors++; if (occupancy !== CW'(4) || stall !== 1'b1) begin miscompares++; $display("FAIL full_next got occ %0d stall %b exp 4 1", occupancy, stall); end
      de_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic [AW-1:0] exp_pc;
         exp_pc = (i == 3) ? 32'h20 : 32'h44 + 32'(4*i);
         vectors++; if (de_pc !== exp_pc) begin miscompares++; $display("FAIL full_order[%0d] got %h exp %h", i, de_pc, exp_pc); end
         tick();
      end
      de_ready = 1'b0;
      vectors++; if (de_valid !== 1'b0) begin miscompares++; $display("FAIL full_order_end got v%b exp v0", de_valid); end
   endtask

   task automatic test_async_reset();
      de_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         fe_valid = 1'b1; fe_pc = 32'h60 + 32'(4*i); fe_isn = 32'h66;
         tick();
      end
      fe_valid = 1'b0;
      vectors++; if (occupancy !== CW'(2)) begin miscompares++; $display("FAIL areset_pre got occ %0d exp 2", occupancy); end
      #2 rst = 1'b0;
      #1;
      vectors++; if (de_valid !== 1'b0 || occupancy !== CW'(0) || stall !== 1'b0 || de_pc !== 32'h0) begin
         miscompares++; $display("FAIL areset_now got v%b occ %0d stall %b pc %h exp v0 0 0 0", de_valid, occupancy, stall, de_pc); end
      #2 rst = 1'b1;
      fe_valid = 1'b1; fe_pc = 32'h70; fe_isn = 32'h77;
      tick();
      fe_valid = 1'b0;
      vectors++; if (de_valid !== 1'b1 || de_pc !== 32'h70 || de_isn !== 32'h77 || occupancy !== CW'(1)) begin
         miscompares++; $display("FAIL areset_after got v%b %h/%h occ %0d exp v1 70/77 1", de_valid, de_pc, de_isn, occupancy); end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b0; fe_valid = 1'b0; fe_pc = '0; fe_isn = '0; flush = 1'b0; de_ready = 1'b0;
      test_reset();
      test_fill();
      test_drain();
      test_stream();
      test_flush();
      test_full_drain();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
